// File: rtl/deser_lock_pkg.sv
// Shared types and helpers for the deser400 lane lock controller.
// Optional error totaliser: define DESER_LOCK_ERRCNT_EN.
package deser_lock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST,
    ST_SETTLE,
    ST_ACQ,
    ST_LOCKED
  } state_t;

  localparam int DEF_NPHASE     = 4;
  localparam int DEF_PHASE_W    = 2;
  localparam int DEF_RST_LEN    = 4;
  localparam int DEF_SETTLE     = 16;
  localparam int DEF_WINDOW     = 256;
  localparam int DEF_UNLOCK_ERR = 4;

  function automatic logic [15:0] sat_inc16(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/deser_lock_window.sv
// Frame/error window counter: rolls over every WINDOW frames and
// flags when the in-window error count reaches UNLOCK_ERR.
module deser_lock_window
  import deser_lock_pkg::*;
#(
  parameter int WINDOW     = DEF_WINDOW,
  parameter int UNLOCK_ERR = DEF_UNLOCK_ERR
) (
  input  logic clk400,
  input  logic reset,
  input  logic clr,
  input  logic en,
  input  logic frame_sync,
  input  logic frame_err,
  output logic win_done,
  output logic err_hit
);

  logic [15:0] frm_cnt;
  logic [15:0] err_cnt;
  logic [15:0] err_next;

  // An error on the closing frame still belongs to the closing window.
  always_comb begin
    err_next = frame_err ? sat_inc16(err_cnt) : err_cnt;
    win_done = en && frame_sync &&
               (frm_cnt == 16'(WINDOW - 1));
    err_hit  = en && frame_err &&
               (err_next >= 16'(UNLOCK_ERR));
  end

  always_ff @(posedge clk400 or posedge reset) begin
    if (reset) begin
      frm_cnt <= '0;
      err_cnt <= '0;
    end else if (clr || win_done) begin
      frm_cnt <= '0;
      err_cnt <= '0;
    end else if (en) begin
      frm_cnt <= frm_cnt + {15'd0, frame_sync};
      err_cnt <= err_next;
    end
  end

endmodule

// File: rtl/deser_lock_ctrl.sv
// Phase-hunt and lock controller for one deser400 lane.
// Optional err_total counter: define DESER_LOCK_ERRCNT_EN.
module deser_lock_ctrl
  import deser_lock_pkg::*;
#(
  parameter int NPHASE     = DEF_NPHASE,
  parameter int PHASE_W    = DEF_PHASE_W,
  parameter int RST_LEN    = DEF_RST_LEN,
  parameter int SETTLE     = DEF_SETTLE,
  parameter int WINDOW     = DEF_WINDOW,
  parameter int UNLOCK_ERR = DEF_UNLOCK_ERR
) (
  input  logic               clk400,
  input  logic               reset,
  input  logic               start,
  input  logic               frame_sync,
  input  logic               frame_err,
  output logic               det_reset,
  output logic               det_enable,
  output logic [PHASE_W-1:0] phase_sel,
  output logic               locked,
  output logic               lock_lost,
  output logic               sweep_fail,
  output logic [15:0]        err_total,
  input  logic               err_clr
);

  state_t             state;
  logic [7:0]         cnt;
  logic [4:0]         sweep_cnt;
  logic [4:0]         sweep_nxt;
  logic [PHASE_W-1:0] phase_nxt;
  logic               in_run;
  logic               win_clr;
  logic               win_done;
  logic               err_hit;

  assign in_run    = (state == ST_ACQ) ||
                     (state == ST_LOCKED);
  assign win_clr   = !start || !in_run;
  assign sweep_nxt = sweep_cnt + 5'd1;
  assign phase_nxt =
    (phase_sel == PHASE_W'(NPHASE - 1)) ?
    '0 : phase_sel + 1'b1;

  deser_lock_window #(
    .WINDOW     (WINDOW),
    .UNLOCK_ERR (UNLOCK_ERR)
  ) u_win (
    .clk400     (clk400),
    .reset      (reset),
    .clr        (win_clr),
    .en         (in_run),
    .frame_sync (frame_sync),
    .frame_err  (frame_err),
    .win_done   (win_done),
    .err_hit    (err_hit)
  );

  always_ff @(posedge clk400 or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      sweep_cnt  <= '0;
      phase_sel  <= '0;
      det_reset  <= 1'b1;
      det_enable <= 1'b0;
      locked     <= 1'b0;
      lock_lost  <= 1'b0;
      sweep_fail <= 1'b0;
    end else begin
      lock_lost  <= 1'b0;
      sweep_fail <= 1'b0;
      if (!start) begin
        state      <= ST_IDLE;
        cnt        <= '0;
        sweep_cnt  <= '0;
        det_reset  <= 1'b0;
        det_enable <= 1'b0;
        locked     <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            state      <= ST_RST;
            cnt        <= '0;
            det_reset  <= 1'b1;
            det_enable <= 1'b0;
          end
          ST_RST: begin
            if (cnt == 8'(RST_LEN - 1)) begin
              state      <= ST_SETTLE;
              cnt        <= '0;
              det_reset  <= 1'b0;
              det_enable <= 1'b1;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
          ST_SETTLE: begin
            if (cnt == 8'(SETTLE - 1)) begin
              state <= ST_ACQ;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
          ST_ACQ: begin
            // A failing error beats a window-closing frame.
            if (frame_err) begin
              state      <= ST_RST;
              cnt        <= '0;
              det_reset  <= 1'b1;
              det_enable <= 1'b0;
              phase_sel  <= phase_nxt;
              if (sweep_nxt == 5'(NPHASE)) begin
                sweep_cnt  <= '0;
                sweep_fail <= 1'b1;
              end else begin
                sweep_cnt <= sweep_nxt;
              end
            end else if (win_done) begin
              state     <= ST_LOCKED;
              locked    <= 1'b1;
              sweep_cnt <= '0;
            end
          end
          ST_LOCKED: begin
            if (err_hit) begin
              state      <= ST_RST;
              cnt        <= '0;
              det_reset  <= 1'b1;
              det_enable <= 1'b0;
              locked     <= 1'b0;
              lock_lost  <= 1'b1;
              phase_sel  <= phase_nxt;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef DESER_LOCK_ERRCNT_EN
  always_ff @(posedge clk400 or posedge reset) begin
    if (reset)
      err_total <= '0;
    else if (err_clr)
      err_total <= '0;
    else if (in_run && frame_err)
      err_total <= sat_inc16(err_total);
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_total      = 16'd0;
`endif

endmodule
